// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if
//
// Bundles every non-clock/reset signal of the ALU sequencer so the instruction
// source, the ALU and the debug port can be wired with a single connection.
//
// Signals:
//   instr_valid / instr / instr_ready : instruction handshake (valid/ready)
//   alu_a / alu_b / alu_fs            : registered operands and function select to the ALU
//   alu_out                           : combinational result coming back from the ALU
//   res_valid / res_data / res_z      : retired-result pulse, held result and zero flag
//   dbg_we / dbg_waddr / dbg_wdata    : debug register-file write port
//   dbg_raddr / dbg_rdata             : debug register-file read port
//
// Modports:
//   master : the environment around the sequencer (instruction source, ALU, debug host)
//   slave  : the sequencer itself

interface alu_sequencer_if #(
  parameter int DATA_W = 16
);

  logic              instr_valid;
  logic [15:0]       instr;
  logic              instr_ready;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_fs;
  logic [DATA_W-1:0] alu_out;

  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_z;

  logic              dbg_we;
  logic [2:0]        dbg_waddr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [2:0]        dbg_raddr;
  logic [DATA_W-1:0] dbg_rdata;

  modport master (
    output instr_valid,
    output instr,
    input  instr_ready,
    input  alu_a,
    input  alu_b,
    input  alu_fs,
    output alu_out,
    input  res_valid,
    input  res_data,
    input  res_z,
    output dbg_we,
    output dbg_waddr,
    output dbg_wdata,
    output dbg_raddr,
    input  dbg_rdata
  );

  modport slave (
    input  instr_valid,
    input  instr,
    output instr_ready,
    output alu_a,
    output alu_b,
    output alu_fs,
    input  alu_out,
    output res_valid,
    output res_data,
    output res_z,
    input  dbg_we,
    input  dbg_waddr,
    input  dbg_wdata,
    input  dbg_raddr,
    output dbg_rdata
  );

endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer
//
// Multi-cycle controller that drives an external 16-bit ALU. It accepts
// register-to-register instructions over a valid/ready handshake, holds an
// 8-entry register file, presents operands/function select to the ALU,
// captures the ALU result, computes the zero flag locally and optionally
// writes the result back.
//
// Instruction format:
//   [15:12] FS, [11:9] rd, [8:6] ra, [5:3] rb, [2] wb_en, [1:0] reserved
//
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : alu_sequencer_if.slave (handshake, ALU side, result, debug port)
//
// Sequence per instruction: IDLE (accept) -> READ -> EXEC -> WB -> IDLE,
// giving one instruction per four cycles at most.

module alu_sequencer #(
  parameter int DATA_W = 16
) (
  input logic           clk,
  input logic           rst,
  alu_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  // Latched instruction fields; the reserved low bits are never needed.
  logic [3:0]        fs_q;
  logic [2:0]        rd_q;
  logic [2:0]        ra_q;
  logic [2:0]        rb_q;
  logic              wb_en_q;

  // Register file. Entry 0 is never written, so it always reads zero.
  logic [DATA_W-1:0] regs [8];

  logic [DATA_W-1:0] alu_a_q;
  logic [DATA_W-1:0] alu_b_q;
  logic [3:0]        alu_fs_q;
  logic [DATA_W-1:0] res_data_q;
  logic              res_z_q;

  // Per-state control strobes produced by the next-state logic.
  logic              ready_c;
  logic              res_valid_c;
  logic              accept_c;
  logic              load_ops_c;
  logic              capture_c;
  logic              write_back_c;
  logic              dbg_write_c;

  // State register. Reset pulls the FSM back to IDLE from anywhere, which
  // also aborts any in-flight instruction before it can retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and control decode. The sequence is strictly linear; only
  // IDLE can linger (waiting for instr_valid). The debug write port is only
  // opened in IDLE so it can never race a write-back from WB.
  always_comb begin
    next_state   = state;
    ready_c      = 1'b0;
    res_valid_c  = 1'b0;
    accept_c     = 1'b0;
    load_ops_c   = 1'b0;
    capture_c    = 1'b0;
    write_back_c = 1'b0;
    dbg_write_c  = 1'b0;
    case (state)
      IDLE: begin
        ready_c     = 1'b1;
        dbg_write_c = bus.dbg_we;
        if (bus.instr_valid) begin
          accept_c   = 1'b1;
          next_state = READ;
        end
      end
      READ: begin
        load_ops_c = 1'b1;
        next_state = EXEC;
      end
      EXEC: begin
        capture_c  = 1'b1;
        next_state = WB;
      end
      WB: begin
        res_valid_c  = 1'b1;
        write_back_c = wb_en_q && (rd_q != 3'd0);
        next_state   = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Instruction latch. Fields are captured only on the accepting edge and
  // stay stable for the rest of the sequence, so the source is free to
  // present its next instruction straight away.
  always_ff @(posedge clk) begin
    if (rst) begin
      fs_q    <= 4'd0;
      rd_q    <= 3'd0;
      ra_q    <= 3'd0;
      rb_q    <= 3'd0;
      wb_en_q <= 1'b0;
    end else if (accept_c) begin
      fs_q    <= bus.instr[15:12];
      rd_q    <= bus.instr[11:9];
      ra_q    <= bus.instr[8:6];
      rb_q    <= bus.instr[5:3];
      wb_en_q <= bus.instr[2];
    end
  end

  // Register file writes. A debug write in the accepting cycle lands on the
  // same edge as the accept, so the following READ already sees it. Writes
  // aimed at R0 are dropped here, which is what keeps R0 reading zero.
  // Debug writes (IDLE only) and write-back (WB only) are mutually exclusive.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (dbg_write_c && (bus.dbg_waddr != 3'd0)) begin
        regs[bus.dbg_waddr] <= bus.dbg_wdata;
      end
      if (write_back_c) begin
        regs[rd_q] <= res_data_q;
      end
    end
  end

  // ALU operand registers. They only change in READ and otherwise hold,
  // so the ALU sees a stable input for the whole EXEC cycle and the last
  // operands remain visible while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_fs_q <= 4'd0;
    end else if (load_ops_c) begin
      alu_a_q  <= regs[ra_q];
      alu_b_q  <= regs[rb_q];
      alu_fs_q <= fs_q;
    end
  end

  // Result capture at the end of EXEC. The ALU output is stored as-is; the
  // zero flag is derived here rather than trusting any flag from the ALU.
  // Both values hold until the next capture, including compare-only runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_data_q <= '0;
      res_z_q    <= 1'b0;
    end else if (capture_c) begin
      res_data_q <= bus.alu_out;
      res_z_q    <= (bus.alu_out == '0);
    end
  end

  // Output drive. The debug read is purely combinational, so a same-cycle
  // write to the same address is only visible after the edge.
  assign bus.instr_ready = ready_c;
  assign bus.res_valid   = res_valid_c;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_fs      = alu_fs_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_z       = res_z_q;
  assign bus.dbg_rdata   = regs[bus.dbg_raddr];

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
//
// Self-checking bench for alu_sequencer. The bench plays both the instruction
// source and the ALU (a small behavioural ALU on alu_out). Expected results
// are computed from a reference register-file model when each instruction is
// issued, pushed to a queue, and popped by a monitor when res_valid pulses.

module tb_alu_sequencer;

  localparam int DATA_W = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_sequencer_if #(.DATA_W(DATA_W)) bus ();

  alu_sequencer #(.DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, otherwise pass A.
  function automatic logic [15:0] alu_model(input logic [3:0] fs,
                                            input logic [15:0] a,
                                            input logic [15:0] b);
    case (fs)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      default: return a;
    endcase
  endfunction

  assign bus.alu_out = alu_model(bus.alu_fs, bus.alu_a, bus.alu_b);

  function automatic logic [15:0] enc(input logic [3:0] fs, input logic [2:0] rd,
                                      input logic [2:0] ra, input logic [2:0] rb,
                                      input logic wb);
    return {fs, rd, ra, rb, wb, 2'b00};
  endfunction

  typedef struct {
    logic [15:0] data;
    logic        z;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model_regs [8];
  int          checks     = 0;
  int          passes     = 0;
  int          res_pulses = 0;
  int          cycle      = 0;

  always @(posedge clk) cycle++;

  // Scoreboard monitor: every retired result must match the oldest
  // outstanding expectation; a pulse with nothing outstanding is an error.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.res_valid === 1'b1) begin
      res_pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_res_valid: got res_valid=1 (data %h) expected no pulse", bus.res_data);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (bus.res_data !== e.data)
          $display("[TB] FAIL sb_res_data: got %h expected %h", bus.res_data, e.data);
        else passes++;
        checks++;
        if (bus.res_z !== e.z)
          $display("[TB] FAIL sb_res_z: got %b expected %b", bus.res_z, e.z);
        else passes++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_write(input logic [2:0] addr, input logic [15:0] data);
    bus.dbg_we    = 1'b1;
    bus.dbg_waddr = addr;
    bus.dbg_wdata = data;
    tick();
    bus.dbg_we = 1'b0;
    if (addr != 3'd0) model_regs[addr] = data;
  endtask

  // Present an instruction and record what it must produce; no ticking.
  task automatic present(input logic [3:0] fs, input logic [2:0] rd,
                         input logic [2:0] ra, input logic [2:0] rb, input logic wb);
    exp_t        e;
    logic [15:0] r;
    bus.instr_valid = 1'b1;
    bus.instr       = enc(fs, rd, ra, rb, wb);
    r      = alu_model(fs, model_regs[ra], model_regs[rb]);
    e.data = r;
    e.z    = (r == 16'h0000);
    exp_q.push_back(e);
    if (wb && rd != 3'd0) model_regs[rd] = r;
  endtask

  // Issue one instruction from IDLE: present, accept edge, drop valid.
  task automatic issue(input logic [3:0] fs, input logic [2:0] rd,
                       input logic [2:0] ra, input logic [2:0] rb, input logic wb);
    present(fs, rd, ra, rb, wb);
    tick();
    bus.instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) model_regs[i] = 16'h0000;
    checks++;
    if (bus.instr_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", bus.instr_ready);
    else passes++;
    checks++;
    if (bus.alu_a !== 16'h0000) $display("[TB] FAIL reset_alu_a: got %h expected 0000", bus.alu_a);
    else passes++;
    checks++;
    if (bus.alu_b !== 16'h0000) $display("[TB] FAIL reset_alu_b: got %h expected 0000", bus.alu_b);
    else passes++;
    checks++;
    if (bus.alu_fs !== 4'h0) $display("[TB] FAIL reset_alu_fs: got %h expected 0", bus.alu_fs);
    else passes++;
    checks++;
    if (bus.res_valid !== 1'b0) $display("[TB] FAIL reset_res_valid: got %b expected 0", bus.res_valid);
    else passes++;
    checks++;
    if (bus.res_data !== 16'h0000 || bus.res_z !== 1'b0)
      $display("[TB] FAIL reset_result: got %h/%b expected 0000/0", bus.res_data, bus.res_z);
    else passes++;
    for (int i = 0; i < 8; i++) begin
      bus.dbg_raddr = 3'(i);
      #1;
      checks++;
      if (bus.dbg_rdata !== 16'h0000)
        $display("[TB] FAIL reset_reg%0d: got %h expected 0000", i, bus.dbg_rdata);
      else passes++;
    end
  endtask

  task automatic test_basic_add();
    tick();
    dbg_write(3'd1, 16'h0005);
    dbg_write(3'd2, 16'h0003);
    issue(4'd0, 3'd3, 3'd1, 3'd2, 1'b1);
    // READ cycle
    checks++;
    if (bus.instr_ready !== 1'b0 || bus.res_valid !== 1'b0)
      $display("[TB] FAIL add_read_cycle: got ready=%b valid=%b expected 0/0", bus.instr_ready, bus.res_valid);
    else passes++;
    // debug write outside IDLE must be ignored
    bus.dbg_we    = 1'b1;
    bus.dbg_waddr = 3'd7;
    bus.dbg_wdata = 16'hBEEF;
    tick();
    bus.dbg_we = 1'b0;
    // EXEC cycle
    checks++;
    if (bus.alu_a !== 16'h0005) $display("[TB] FAIL add_alu_a: got %h expected 0005", bus.alu_a);
    else passes++;
    checks++;
    if (bus.alu_b !== 16'h0003) $display("[TB] FAIL add_alu_b: got %h expected 0003", bus.alu_b);
    else passes++;
    checks++;
    if (bus.alu_fs !== 4'h0) $display("[TB] FAIL add_alu_fs: got %h expected 0", bus.alu_fs);
    else passes++;
    checks++;
    if (bus.res_valid !== 1'b0) $display("[TB] FAIL add_exec_valid: got %b expected 0", bus.res_valid);
    else passes++;
    tick();
    // WB cycle: three cycles after accept
    checks++;
    if (bus.res_valid !== 1'b1) $display("[TB] FAIL add_wb_valid: got %b expected 1", bus.res_valid);
    else passes++;
    checks++;
    if (bus.res_data !== 16'h0008 || bus.res_z !== 1'b0)
      $display("[TB] FAIL add_wb_result: got %h/%b expected 0008/0", bus.res_data, bus.res_z);
    else passes++;
    tick();
    checks++;
    if (bus.res_valid !== 1'b0 || bus.instr_ready !== 1'b1)
      $display("[TB] FAIL add_back_idle: got valid=%b ready=%b expected 0/1", bus.res_valid, bus.instr_ready);
    else passes++;
    checks++;
    if (bus.alu_a !== 16'h0005) $display("[TB] FAIL add_alu_a_hold: got %h expected 0005", bus.alu_a);
    else passes++;
    bus.dbg_raddr = 3'd3;
    #1;
    checks++;
    if (bus.dbg_rdata !== model_regs[3]) $display("[TB] FAIL add_r3: got %h expected %h", bus.dbg_rdata, model_regs[3]);
    else passes++;
    bus.dbg_raddr = 3'd7;
    #1;
    checks++;
    if (bus.dbg_rdata !== model_regs[7]) $display("[TB] FAIL add_dbg_ignored: got %h expected %h", bus.dbg_rdata, model_regs[7]);
    else passes++;
  endtask

  task automatic test_zero_compare();
    dbg_write(3'd4, 16'h00AA);
    issue(4'd1, 3'd4, 3'd1, 3'd1, 1'b1);
    tick();
    tick();
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_z !== 1'b1 || bus.res_data !== 16'h0000)
      $display("[TB] FAIL sub_zero: got v=%b z=%b d=%h expected 1/1/0000", bus.res_valid, bus.res_z, bus.res_data);
    else passes++;
    tick();
    bus.dbg_raddr = 3'd4;
    #1;
    checks++;
    if (bus.dbg_rdata !== model_regs[4]) $display("[TB] FAIL sub_r4: got %h expected %h", bus.dbg_rdata, model_regs[4]);
    else passes++;
    issue(4'd0, 3'd4, 3'd1, 3'd2, 1'b0);
    tick();
    tick();
    tick();
    checks++;
    if (bus.res_data !== 16'h0008 || bus.res_z !== 1'b0)
      $display("[TB] FAIL cmp_result_hold: got %h/%b expected 0008/0", bus.res_data, bus.res_z);
    else passes++;
    bus.dbg_raddr = 3'd4;
    #1;
    checks++;
    if (bus.dbg_rdata !== model_regs[4]) $display("[TB] FAIL cmp_r4_unchanged: got %h expected %h", bus.dbg_rdata, model_regs[4]);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int acc1;
    int acc2;
    int low;
    present(4'd0, 3'd3, 3'd1, 3'd2, 1'b1);
    checks++;
    if (bus.instr_ready !== 1'b1) $display("[TB] FAIL b2b_ready_first: got %b expected 1", bus.instr_ready);
    else passes++;
    tick();
    acc1 = cycle;
    present(4'd0, 3'd5, 3'd3, 3'd3, 1'b1);
    low = 0;
    while (bus.instr_ready !== 1'b1 && low < 10) begin
      low++;
      tick();
    end
    checks++;
    if (low != 3) $display("[TB] FAIL b2b_ready_low_1: got %0d cycles expected 3", low);
    else passes++;
    tick();
    acc2 = cycle;
    bus.instr_valid = 1'b0;
    checks++;
    if (acc2 - acc1 != 4) $display("[TB] FAIL b2b_accept_gap: got %0d expected 4", acc2 - acc1);
    else passes++;
    low = 0;
    while (bus.instr_ready !== 1'b1 && low < 10) begin
      low++;
      tick();
    end
    checks++;
    if (low != 3) $display("[TB] FAIL b2b_ready_low_2: got %0d cycles expected 3", low);
    else passes++;
    checks++;
    if (bus.res_data !== 16'h0010) $display("[TB] FAIL b2b_res: got %h expected 0010", bus.res_data);
    else passes++;
    bus.dbg_raddr = 3'd5;
    #1;
    checks++;
    if (bus.dbg_rdata !== model_regs[5]) $display("[TB] FAIL b2b_r5: got %h expected %h", bus.dbg_rdata, model_regs[5]);
    else passes++;
  endtask

  task automatic test_wrap_r0();
    dbg_write(3'd1, 16'hFFFF);
    // debug write of R2 in the accepting cycle must be seen by READ
    model_regs[2] = 16'h0001;
    bus.dbg_we    = 1'b1;
    bus.dbg_waddr = 3'd2;
    bus.dbg_wdata = 16'h0001;
    issue(4'd0, 3'd0, 3'd1, 3'd2, 1'b1);
    bus.dbg_we = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (bus.res_data !== 16'h0000 || bus.res_z !== 1'b1)
      $display("[TB] FAIL wrap_result: got %h/%b expected 0000/1", bus.res_data, bus.res_z);
    else passes++;
    bus.dbg_raddr = 3'd0;
    #1;
    checks++;
    if (bus.dbg_rdata !== 16'h0000) $display("[TB] FAIL wrap_r0: got %h expected 0000", bus.dbg_rdata);
    else passes++;
    dbg_write(3'd0, 16'h1234);
    bus.dbg_raddr = 3'd0;
    #1;
    checks++;
    if (bus.dbg_rdata !== 16'h0000) $display("[TB] FAIL dbg_r0: got %h expected 0000", bus.dbg_rdata);
    else passes++;
  endtask

  task automatic test_reset_mid_op();
    int pulses_before;
    dbg_write(3'd1, 16'h0005);
    dbg_write(3'd2, 16'h0003);
    dbg_write(3'd3, 16'h0000);
    pulses_before   = res_pulses;
    bus.instr_valid = 1'b1;
    bus.instr       = enc(4'd0, 3'd3, 3'd1, 3'd2, 1'b1);
    tick();
    bus.instr_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) model_regs[i] = 16'h0000;
    checks++;
    if (bus.instr_ready !== 1'b1 || bus.res_valid !== 1'b0)
      $display("[TB] FAIL midrst_idle: got ready=%b valid=%b expected 1/0", bus.instr_ready, bus.res_valid);
    else passes++;
    checks++;
    if (bus.alu_a !== 16'h0000 || bus.res_data !== 16'h0000)
      $display("[TB] FAIL midrst_regs: got alu_a=%h res=%h expected 0000/0000", bus.alu_a, bus.res_data);
    else passes++;
    tick();
    tick();
    checks++;
    if (res_pulses != pulses_before) $display("[TB] FAIL midrst_no_pulse: got %0d pulses expected %0d", res_pulses, pulses_before);
    else passes++;
    bus.dbg_raddr = 3'd3;
    #1;
    checks++;
    if (bus.dbg_rdata !== model_regs[3]) $display("[TB] FAIL midrst_r3: got %h expected %h", bus.dbg_rdata, model_regs[3]);
    else passes++;
  endtask

  initial begin
    rst             = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0000;
    bus.dbg_we      = 1'b0;
    bus.dbg_waddr   = 3'd0;
    bus.dbg_wdata   = 16'h0000;
    bus.dbg_raddr   = 3'd0;
    $display("[TB] start");
    test_reset();
    test_basic_add();
    test_zero_compare();
    test_back_to_back();
    test_wrap_r0();
    test_reset_mid_op();
    tick();
    checks++;
    if (exp_q.size() != 0) $display("[TB] FAIL sb_drained: got %0d outstanding expected 0", exp_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
